// File: rtl/proc_ctrl_pkg.sv
// Shared types and helpers for the processor run controller.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  typedef struct packed {
    logic proc_reset;
    logic proc_run;
    logic busy;
    logic done;
  } ctrl_t;

  // Bits needed to hold values 0..n; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE:       c.proc_reset = 1'b1;
      RESET_HOLD: begin c.proc_reset = 1'b1; c.busy = 1'b1; end
      RUN:        begin c.proc_run = 1'b1; c.busy = 1'b1; end
      DONE:       c.done = 1'b1;
      default:    c.proc_reset = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en && (q != '1))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/proc_run_controller.sv
// Run controller: reset-hold, bounded run, freeze, with cycle/zero counters.
// Optional build macro ZERO_HALT_EN adds a halt on ZERO_HALT_CNT consecutive zero cycles.
module proc_run_controller
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned MAX_CYCLES    = 22,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned ZERO_HALT_CNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             zero,
  output logic             proc_reset,
  output logic             proc_run,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] zero_count
);

  localparam int unsigned HW = cnt_w(RST_CYCLES);

  state_t        state, nxt;
  ctrl_t         ctrl;
  logic [HW-1:0] hold, hold_nxt;
  logic          timeout_nxt;
  logic          launch;
  logic          run_en, zero_en;
  logic          last_cycle;
  logic          zero_halt;

  assign run_en     = (state == RUN);
  assign zero_en    = run_en & zero;
  assign last_cycle = (cycle_count == CNT_W'(MAX_CYCLES - 1));

  always_comb begin
    nxt         = state;
    hold_nxt    = hold;
    timeout_nxt = timeout;
    launch      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch      = 1'b1;
          nxt         = RESET_HOLD;
          hold_nxt    = HW'(RST_CYCLES - 1);
          timeout_nxt = 1'b0;
        end
      end
      RESET_HOLD: begin
        if (abort) begin
          nxt         = DONE;
          timeout_nxt = 1'b0;
        end else if (hold == '0) begin
          nxt = RUN;
        end else begin
          hold_nxt = hold - 1'b1;
        end
      end
      RUN: begin
        // abort outranks zero-halt, which outranks timeout
        if (abort || zero_halt) begin
          nxt         = DONE;
          timeout_nxt = 1'b0;
        end else if (last_cycle) begin
          nxt         = DONE;
          timeout_nxt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ctrl    <= decode(IDLE);
      hold    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= nxt;
      ctrl    <= decode(nxt);
      hold    <= hold_nxt;
      timeout <= timeout_nxt;
    end
  end

  assign proc_reset = ctrl.proc_reset;
  assign proc_run   = ctrl.proc_run;
  assign busy       = ctrl.busy;
  assign done       = ctrl.done;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (launch),
    .en    (run_en),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_zero_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (launch),
    .en    (zero_en),
    .q     (zero_count)
  );

`ifdef ZERO_HALT_EN
  localparam int unsigned ZW = cnt_w(ZERO_HALT_CNT);

  logic [ZW-1:0] streak;

  sat_counter #(.W(ZW)) u_streak_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (launch | (run_en & ~zero)),
    .en    (zero_en),
    .q     (streak)
  );

  assign zero_halt = zero_en && (streak == ZW'(ZERO_HALT_CNT - 1));
`else
  // No streak logic in this build; the parameter is still referenced so overrides stay legal.
  assign zero_halt = (ZERO_HALT_CNT == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_proc_run_controller.sv
// Self-checking bench for proc_run_controller against a run-level reference model.
module tb_proc_run_controller;

  localparam int unsigned RST = 2;
  localparam int unsigned MAX = 22;
  localparam int unsigned CW  = 16;
  localparam int unsigned ZHC = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, abort = 1'b0, zero = 1'b0;
  logic          proc_reset, proc_run, busy, done, timeout;
  logic [CW-1:0] cycle_count, zero_count;

  logic          start_b = 1'b0, abort_b = 1'b0, zero_b = 1'b0;
  logic          proc_reset_b, proc_run_b, busy_b, done_b, timeout_b;
  logic [3:0]    cycle_count_b, zero_count_b;

  always #20 clock = ~clock;

  proc_run_controller #(.RST_CYCLES(RST), .MAX_CYCLES(MAX), .CNT_W(CW), .ZERO_HALT_CNT(ZHC)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .zero(zero),
    .proc_reset(proc_reset), .proc_run(proc_run), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count), .zero_count(zero_count)
  );

  proc_run_controller #(.RST_CYCLES(1), .MAX_CYCLES(1), .CNT_W(4), .ZERO_HALT_CNT(ZHC)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort_b), .zero(zero_b),
    .proc_reset(proc_reset_b), .proc_run(proc_run_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .cycle_count(cycle_count_b), .zero_count(zero_count_b)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Stimulus for one run: zero flag per RUN cycle, and the RUN cycle that sees abort (0 = none).
  bit          zv [1:MAX];
  int unsigned abort_at;

  // Run length, timeout and zero count derived from the run-level rules.
  task automatic predict(output int unsigned n, output bit to, output int unsigned zc);
    int unsigned halt_j = 0;
    int unsigned s = 0;
    n = MAX;
    if (abort_at != 0 && abort_at < n) n = abort_at;
`ifdef ZERO_HALT_EN
    for (int unsigned j = 1; j <= MAX; j++) begin
      s = zv[j] ? s + 1 : 0;
      if (s == ZHC) begin
        halt_j = j;
        break;
      end
    end
    if (halt_j != 0 && halt_j < n) n = halt_j;
`endif
    to = (n == MAX) && (abort_at != n) && (halt_j != n);
    zc = 0;
    for (int unsigned j = 1; j <= n; j++) zc += zv[j];
  endtask

  task automatic clear_stim();
    for (int unsigned j = 1; j <= MAX; j++) zv[j] = 1'b0;
    abort_at = 0;
  endtask

  // Entered at posedge+1 with the DUT in IDLE or DONE.
  task automatic run_once(input string name);
    int unsigned n, zc, zsum;
    bit          to, in_rh, in_run, in_done;
    predict(n, to, zc);
    zsum  = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int unsigned t = 1; t <= RST + n + 1; t++) begin
      in_rh   = (t <= RST);
      in_run  = (t > RST) && (t <= RST + n);
      in_done = (t > RST + n);
      expect_eq($sformatf("%s.proc_reset@%0d", name, t), proc_reset, in_rh);
      expect_eq($sformatf("%s.proc_run@%0d", name, t), proc_run, in_run);
      expect_eq($sformatf("%s.busy@%0d", name, t), busy, in_rh | in_run);
      expect_eq($sformatf("%s.done@%0d", name, t), done, in_done);
      if (in_rh) begin
        expect_eq($sformatf("%s.cyc_clr@%0d", name, t), cycle_count, 0);
        expect_eq($sformatf("%s.zc_clr@%0d", name, t), zero_count, 0);
        expect_eq($sformatf("%s.to_clr@%0d", name, t), timeout, 0);
        zero  = ($urandom_range(0, 1) == 1);
        abort = 1'b0;
        start = ($urandom_range(0, 3) == 0);
      end else if (in_run) begin
        expect_eq($sformatf("%s.cyc@%0d", name, t), cycle_count, t - RST - 1);
        expect_eq($sformatf("%s.zc@%0d", name, t), zero_count, zsum);
        zero  = zv[t - RST];
        zsum += zv[t - RST];
        abort = (t - RST == abort_at);
        start = ($urandom_range(0, 3) == 0);
      end else begin
        expect_eq($sformatf("%s.timeout", name), timeout, to);
        expect_eq($sformatf("%s.cycle_count", name), cycle_count, n);
        expect_eq($sformatf("%s.zero_count", name), zero_count, zc);
        zero  = ($urandom_range(0, 1) == 1);
        abort = ($urandom_range(0, 1) == 1);
        start = 1'b0;
      end
      @(posedge clock); #1;
    end
    zero  = 1'b0;
    abort = 1'b0;
    expect_eq({name, ".hold_done"}, done, 1);
    expect_eq({name, ".hold_to"}, timeout, to);
    expect_eq({name, ".hold_cyc"}, cycle_count, n);
    expect_eq({name, ".hold_zc"}, zero_count, zc);
  endtask

  task automatic expect_idle(input string name);
    expect_eq({name, ".proc_reset"}, proc_reset, 1);
    expect_eq({name, ".proc_run"}, proc_run, 0);
    expect_eq({name, ".busy"}, busy, 0);
    expect_eq({name, ".done"}, done, 0);
    expect_eq({name, ".timeout"}, timeout, 0);
    expect_eq({name, ".cycle_count"}, cycle_count, 0);
    expect_eq({name, ".zero_count"}, zero_count, 0);
  endtask

  initial begin
    clear_stim();
    repeat (2) @(posedge clock);
    #1;
    expect_idle("por");
    expect_eq("por_b.proc_reset", proc_reset_b, 1);
    expect_eq("por_b.busy", busy_b, 0);
    expect_eq("por_b.cycle_count", cycle_count_b, 0);

    reset = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    expect_idle("idle_abort");

    run_once("full");

    clear_stim();
    zv[3] = 1'b1; zv[4] = 1'b1; zv[10] = 1'b1;
    run_once("zeros");

    clear_stim();
    abort_at = 7;
    run_once("abort7");

    clear_stim();
    for (int unsigned j = 5; j <= 8; j++) zv[j] = 1'b1;
    run_once("streak4");

    clear_stim();
    for (int unsigned j = 5; j <= 7; j++) zv[j] = 1'b1;
    for (int unsigned j = 12; j <= 14; j++) zv[j] = 1'b1;
    run_once("streak3");

    clear_stim();
    abort_at = MAX;
    run_once("abort_last");

    // abort during the reset-hold phase
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    expect_eq("abort_rh.done", done, 1);
    expect_eq("abort_rh.timeout", timeout, 0);
    expect_eq("abort_rh.cycle_count", cycle_count, 0);
    expect_eq("abort_rh.proc_run", proc_run, 0);

    // asynchronous reset between clock edges while running
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    zero  = 1'b1;
    repeat (6) @(posedge clock);
    #5;
    expect_eq("pre_rst.proc_run", proc_run, 1);
    reset = 1'b0;
    #1;
    zero = 1'b0;
    expect_idle("async_rst");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    clear_stim();
    run_once("after_rst");

    for (int unsigned r = 0; r < 8; r++) begin
      clear_stim();
      for (int unsigned j = 1; j <= MAX; j++) zv[j] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) abort_at = $urandom_range(1, MAX);
      run_once($sformatf("rand%0d", r));
    end

    // single-cycle phases on the narrow instance
    start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    expect_eq("b1.proc_reset", proc_reset_b, 1);
    expect_eq("b1.busy", busy_b, 1);
    expect_eq("b1.proc_run", proc_run_b, 0);
    @(posedge clock); #1;
    expect_eq("b1.run", proc_run_b, 1);
    expect_eq("b1.run_cyc", cycle_count_b, 0);
    abort_b = 1'b1;
    zero_b  = 1'b1;
    @(posedge clock); #1;
    abort_b = 1'b0;
    zero_b  = 1'b0;
    expect_eq("b1.done", done_b, 1);
    expect_eq("b1.timeout", timeout_b, 0);
    expect_eq("b1.cycle_count", cycle_count_b, 1);
    expect_eq("b1.zero_count", zero_count_b, 1);

    start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    expect_eq("b2.busy", busy_b, 1);
    expect_eq("b2.cyc_clr", cycle_count_b, 0);
    expect_eq("b2.zc_clr", zero_count_b, 0);
    expect_eq("b2.to_clr", timeout_b, 0);
    @(posedge clock); #1;
    expect_eq("b2.run", proc_run_b, 1);
    @(posedge clock); #1;
    expect_eq("b2.done", done_b, 1);
    expect_eq("b2.timeout", timeout_b, 1);
    expect_eq("b2.cycle_count", cycle_count_b, 1);
    expect_eq("b2.proc_run", proc_run_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
